// File: rtl/mips_pkg.sv
// Shared decode constants, FSM state and jump-kind types for the ID-stage jump logic.
package mips_pkg;

  localparam logic [5:0] OP_J        = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03;
  localparam logic [5:0] FN_JR       = 6'h08;
  localparam logic [5:0] FN_JALR     = 6'h09;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT_RS, REDIRECT, FLUSH} jr_state_t;

  typedef enum logic [2:0] {JK_NONE, JK_J, JK_JAL, JK_JR, JK_JALR} jump_kind_t;

  // Register-indirect jumps need a forwarded rs value before they can redirect.
  function automatic logic is_reg_jump(input jump_kind_t k);
    return (k == JK_JR) || (k == JK_JALR);
  endfunction

  // Jumps that also write a return address.
  function automatic logic is_link_jump(input jump_kind_t k);
    return (k == JK_JAL) || (k == JK_JALR);
  endfunction

endpackage

// File: rtl/jump_decode.sv
// Combinational classifier of the ID instruction into one of the four jump kinds.
module jump_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [1:0] ALUOp,
  input  logic [5:0] Function,
  input  logic       en_jalr,
  output jump_kind_t kind
);

  // Opcode-level jumps take precedence; R-type jumps need the main decoder's ALUOp tag.
  always_comb begin
    kind = JK_NONE;
    if (opcode == OP_J) begin
      kind = JK_J;
    end else if (opcode == OP_JAL) begin
      kind = JK_JAL;
    end else if (ALUOp == ALUOP_RTYPE) begin
      if (Function == FN_JR) begin
        kind = JK_JR;
      end else if (Function == FN_JALR && en_jalr) begin
        kind = JK_JALR;
      end
    end
  end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// ID-stage jump controller: registered PC redirect, link write request, rs-wait stall
// and a multi-cycle IF flush after every taken jump.
module jump_redirect_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter bit EN_JALR      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [5:0]        opcode,
  input  logic [1:0]        ALUOp,
  input  logic [5:0]        Function,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] id_pc_plus4,
  input  logic [ADDR_W-1:0] rs_data,
  input  logic              rs_ready,
  input  logic              ex_flush,
  output logic              stall_id,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if,
  output logic              link_valid,
  output logic [ADDR_W-1:0] link_addr,
  output logic [4:0]        link_rd,
  output logic              misalign
);

  localparam int CNT_W = 3;
  // Bits below the 256 MB region boundary are replaced by the J-format target.
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  jr_state_t         state;
  logic [CNT_W-1:0]  cnt;
  jump_kind_t        kind_q;
  logic [ADDR_W-1:0] pc4_q;
  logic [4:0]        rd_q;

  jump_kind_t        dec_kind;
  logic              accept;
  logic              issue;
  jump_kind_t        issue_kind;
  logic [ADDR_W-1:0] issue_pc4;
  logic [4:0]        issue_rd;
  logic [ADDR_W-1:0] direct_target;
  logic [ADDR_W-1:0] reg_target;
  logic [4:0]        dec_rd;

  jump_decode u_decode (
    .opcode   (opcode),
    .ALUOp    (ALUOp),
    .Function (Function),
    .en_jalr  (EN_JALR),
    .kind     (dec_kind)
  );

  assign direct_target = (id_pc_plus4 & ~LOW28_MASK) | ADDR_W'({imm26, 2'b00});
  assign reg_target    = {rs_data[ADDR_W-1:2], 2'b00};
  assign dec_rd        = (dec_kind == JK_JAL) ? 5'd31 : imm26[15:11];
  assign accept        = (state == IDLE) && id_valid && !ex_flush && (dec_kind != JK_NONE);

  assign stall_id = !ex_flush &&
                    (((state == IDLE) && id_valid && is_reg_jump(dec_kind) && !rs_ready) ||
                     ((state == WAIT_RS) && !rs_ready));

  // Select whether a redirect fires this cycle and which jump's link info it carries.
  always_comb begin
    issue      = 1'b0;
    issue_kind = dec_kind;
    issue_pc4  = id_pc_plus4;
    issue_rd   = dec_rd;
    if (accept && (!is_reg_jump(dec_kind) || rs_ready)) begin
      issue = 1'b1;
    end else if ((state == WAIT_RS) && !ex_flush && rs_ready) begin
      issue      = 1'b1;
      issue_kind = kind_q;
      issue_pc4  = pc4_q;
      issue_rd   = rd_q;
    end
  end

  // Jump sequencing FSM with registered redirect, link and flush outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      kind_q         <= JK_NONE;
      pc4_q          <= '0;
      rd_q           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if       <= 1'b0;
      link_valid     <= 1'b0;
      link_addr      <= '0;
      link_rd        <= '0;
      misalign       <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      link_valid     <= 1'b0;
      misalign       <= 1'b0;
      flush_if       <= 1'b0;
      if (issue) begin
        state          <= REDIRECT;
        redirect_valid <= 1'b1;
        flush_if       <= 1'b1;
        redirect_pc    <= is_reg_jump(issue_kind) ? reg_target : direct_target;
        misalign       <= is_reg_jump(issue_kind) && (rs_data[1:0] != 2'b00);
        if (is_link_jump(issue_kind)) begin
          link_valid <= 1'b1;
          link_addr  <= issue_pc4 + ADDR_W'(4);
          link_rd    <= issue_rd;
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              kind_q <= dec_kind;
              pc4_q  <= id_pc_plus4;
              rd_q   <= dec_rd;
              state  <= WAIT_RS;
            end
          end
          WAIT_RS: begin
            if (ex_flush) state <= IDLE;
          end
          REDIRECT: begin
            if (FLUSH_CYCLES == 1) begin
              state <= IDLE;
            end else begin
              cnt      <= CNT_W'(FLUSH_CYCLES - 1);
              flush_if <= 1'b1;
              state    <= FLUSH;
            end
          end
          FLUSH: begin
            if (cnt <= CNT_W'(1)) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt      <= cnt - CNT_W'(1);
              flush_if <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
